prach_hb2_sched: RTL and testbench
==================================

# prach_hb2_sched

Time-slot scheduler that feeds the two-lane PRACH half-band-2 decimation datapath. It arbitrates `NUM_CH` per-carrier sample requesters into the fixed TDM input stream the HB2 channels expect: data, valid, channel tag and a round-start sync. Requesters are fixed round-robin slots. A slot is never skipped or reassigned, so each carrier keeps a constant position in the interleave.

## Interface
- `NUM_CH`, default 4: number of requesters/carriers, 2..16.
- `SLOT_CYCLES`, default 2: clock cycles per slot, ≥1. One round is `NUM_CH*SLOT_CYCLES` cycles.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `enable`  in  1  level; start/stop scheduling.
- `ch_mask`  in  NUM_CH  1 = carrier active; sampled only at round start.
- `req_valid`  in  NUM_CH  requester c has a sample.
- `req_ready`  out  NUM_CH  pop strobe to requester c (combinational).
- `req_dp1`, `req_dp2`  in  NUM_CH×2×16  per-requester, per-lane sample pairs.
- `din_dp1`, `din_dp2`  out  2×16  lane samples to HB2.
- `din_dv`  out  1  sample valid to HB2.
- `din_chn`  out  8  carrier index of the issued sample.
- `sync_in`  out  1  round-start marker to HB2.
- `underflow`  out  NUM_CH  sticky: active carrier had no sample in its slot.
- `underflow_clr`  in  1  clears all `underflow` bits.
- `busy`  out  1  state ≠ IDLE.

## Operation
- FSM states are IDLE, RUN and DRAIN.
  - IDLE → RUN when `enable`=1. On entry, the slot counter and channel index are set to 0 and `ch_mask` is latched into `act_mask`.
  - RUN → DRAIN when `enable`=0.
  - DRAIN finishes the current round, then goes to IDLE. If `enable` returns to 1 during DRAIN, the block returns to RUN without a gap at the next round boundary.
- `slot_cnt` counts 0..SLOT_CYCLES-1 and wraps. `ch_idx` advances on each wrap, counts 0..NUM_CH-1 and wraps. A `ch_idx` wrap is a round boundary, where `act_mask` is reloaded from `ch_mask`.
- Grant happens at `slot_cnt`=0 in RUN or DRAIN:
  - `req_ready[ch_idx] = act_mask[ch_idx] & req_valid[ch_idx]`. All other `req_ready` bits are 0.
  - On grant, `req_dp1/dp2[ch_idx]` are registered into `din_dp1/dp2`. The same registration sets `din_dv`=1 and `din_chn`=ch_idx, zero-extended.
  - Active carrier with no valid sample: set `underflow[ch_idx]`. `din_dv`=0, no pop.
  - Masked carrier: `din_dv`=0, no pop, no underflow.
- `sync_in`=1 on the output cycle of every slot where `ch_idx`=0 and `slot_cnt`=0, including non-issuing slots. That makes it exactly one pulse per round.
- When `din_dv`=0, `din_dp*` hold their last value and `din_chn` holds its last value.
- Underflow set and `underflow_clr` in the same cycle: set wins for that bit, other bits clear.

## Timing
- Reset values: `din_dp*`=0, `din_dv`=0, `din_chn`=0, `sync_in`=0, `underflow`=0, `busy`=0, state IDLE, counters 0. `req_ready` is 0 because its gating state is reset.
- `req_ready` and grant are in the same cycle, T. `din_*` and `sync_in` are valid at T+1, giving 1 cycle latency.
- `din_dv` is high for exactly 1 cycle per granted slot. With SLOT_CYCLES=1 it can be high every cycle.
- First grant is in the cycle after IDLE→RUN, for channel 0. That cycle is also the first `sync_in` at +1.
- Mid-round `ch_mask` changes take effect only at the next round boundary.
- `rst` mid-round aborts immediately. No `req_ready` is issued in the reset cycle. Outputs take reset values on the next edge.
- `busy` drops the cycle after the last DRAIN slot completes.

## Test plan
- NUM_CH=4, SLOT_CYCLES=2, all valid, mask=4'hF, enable held: `din_dv` pulses every 2 cycles. `din_chn` sequence is 0,1,2,3,0… `sync_in` coincides with every chn=0 and repeats every 8 cycles. Data matches requester values with 1-cycle latency.
- Mask=4'b1010: `din_dv` only for chn 1 and 3 at fixed slot positions. `sync_in` still pulses every 8 cycles. `req_ready[0]` and `req_ready[2]` are never asserted.
- `req_valid[2]`=0 for one round with mask=4'hF: `underflow`=4'b0100 and stays set. Pulsing `underflow_clr` together with a repeat underflow on ch2 leaves bit 2 set. A clear with no underflow gives 0.
- Drop `enable` during ch1's slot: ch2 and ch3 are still issued, then IDLE and `busy`=0. Re-assert `enable` in DRAIN: scheduling continues with no missing round.
- Assert `rst` during ch2's grant cycle: no `req_ready` in that cycle, all outputs 0 next cycle. After release with `enable`=1, the first issue is chn=0 with `sync_in`=1.
- Change `ch_mask` mid-round from 4'hF to 4'h1: the current round completes with all 4 carriers, and the next round issues only chn 0.

Source files
------------

// File: rtl/prach_hb2_sched.sv
`default_nettype none
// ============================================================================
// Module      : prach_hb2_sched
// Description : Fixed round-robin TDM slot scheduler feeding the PRACH HB2 lanes.
// Revision    : 1.0
// ============================================================================
module prach_hb2_sched #(
    parameter int NUM_CH      = 4,
    parameter int SLOT_CYCLES = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic [NUM_CH-1:0]             ch_mask,
    input  logic [NUM_CH-1:0]             req_valid,
    output logic [NUM_CH-1:0]             req_ready,
    input  logic [NUM_CH-1:0][1:0][15:0]  req_dp1,
    input  logic [NUM_CH-1:0][1:0][15:0]  req_dp2,
    output logic [1:0][15:0]              din_dp1,
    output logic [1:0][15:0]              din_dp2,
    output logic                          din_dv,
    output logic [7:0]                    din_chn,
    output logic                          sync_in,
    output logic [NUM_CH-1:0]             underflow,
    input  logic                          underflow_clr,
    output logic                          busy
);

    localparam int CW = $clog2(NUM_CH);
    localparam int SW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam logic [CW-1:0] c_ch_last   = CW'(NUM_CH - 1);
    localparam logic [SW-1:0] c_slot_last = SW'(SLOT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [SW-1:0]     r_slot_cnt;
    logic [CW-1:0]     r_ch_idx;
    logic [NUM_CH-1:0] r_act_mask;

    logic              w_active, w_slot_start, w_slot_end, w_round_end;
    logic              w_grant, w_miss;
    logic [NUM_CH-1:0] w_sel, w_under_set;

    always_comb begin
        w_active     = (r_state != S_IDLE);
        w_slot_start = w_active && (r_slot_cnt == '0);
        w_slot_end   = (r_slot_cnt == c_slot_last);
        w_round_end  = w_slot_end && (r_ch_idx == c_ch_last);
        w_sel           = '0;
        w_sel[r_ch_idx] = 1'b1;
        w_grant      = w_slot_start && r_act_mask[r_ch_idx] && req_valid[r_ch_idx];
        w_miss       = w_slot_start && r_act_mask[r_ch_idx] && !req_valid[r_ch_idx];
        // A synchronous reset in flight must not pop a requester.
        req_ready    = (w_grant && !rst) ? w_sel : '0;
        w_under_set  = w_miss ? w_sel : '0;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (enable) w_state_nxt = S_RUN;
            S_RUN:   if (!enable) w_state_nxt = w_round_end ? S_IDLE : S_DRAIN;
            S_DRAIN: if (w_round_end) w_state_nxt = enable ? S_RUN : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_slot_cnt <= '0;
            r_ch_idx   <= '0;
            r_act_mask <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (!w_active) begin
                r_slot_cnt <= '0;
                r_ch_idx   <= '0;
                if (enable) r_act_mask <= ch_mask;
            end else begin
                r_slot_cnt <= w_slot_end ? '0 : r_slot_cnt + 1'b1;
                if (w_slot_end) r_ch_idx <= w_round_end ? '0 : r_ch_idx + 1'b1;
                if (w_round_end) r_act_mask <= ch_mask;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            din_dp1   <= '0;
            din_dp2   <= '0;
            din_dv    <= 1'b0;
            din_chn   <= '0;
            sync_in   <= 1'b0;
            underflow <= '0;
        end else begin
            din_dv    <= w_grant;
            sync_in   <= w_slot_start && (r_ch_idx == '0);
            // Set beats clear on the same bit.
            underflow <= (underflow & ~{NUM_CH{underflow_clr}}) | w_under_set;
            if (w_grant) begin
                din_dp1 <= req_dp1[r_ch_idx];
                din_dp2 <= req_dp2[r_ch_idx];
                din_chn <= 8'(r_ch_idx);
            end
        end
    end

    assign busy = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_prach_hb2_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_prach_hb2_sched
// Description : Self-checking bench for prach_hb2_sched against a round/position model.
// Revision    : 1.0
// ============================================================================
module tb_prach_hb2_sched;

    localparam int N = 4;
    localparam int S = 2;
    localparam int R = N * S;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                    rst, enable, underflow_clr;
    logic [N-1:0]            ch_mask, req_valid, req_ready, underflow;
    logic [N-1:0][1:0][15:0] req_dp1, req_dp2;
    logic [1:0][15:0]        din_dp1, din_dp2;
    logic                    din_dv, sync_in, busy;
    logic [7:0]              din_chn;

    prach_hb2_sched #(.NUM_CH(N), .SLOT_CYCLES(S)) dut (
        .clk(clk), .rst(rst), .enable(enable), .ch_mask(ch_mask),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_dp1(req_dp1), .req_dp2(req_dp2),
        .din_dp1(din_dp1), .din_dp2(din_dp2), .din_dv(din_dv),
        .din_chn(din_chn), .sync_in(sync_in), .underflow(underflow),
        .underflow_clr(underflow_clr), .busy(busy)
    );

    int checks = 0;
    int errors = 0;

    // Model: running flag plus position within the current round.
    bit               m_known  = 1'b0;
    bit               m_active = 1'b0;
    int               m_pos    = 0;
    logic [N-1:0]     m_mask   = '0;
    logic [1:0][15:0] e_dp1 = '0, e_dp2 = '0;
    logic             e_dv = 1'b0, e_sync = 1'b0, e_busy = 1'b0;
    logic [7:0]       e_chn = '0;
    logic [N-1:0]     e_under = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic step(input bit r, input bit en, input logic [N-1:0] m,
                        input logic [N-1:0] v, input bit clr, input bit rnd);
        logic [N-1:0] e_ready, miss;
        int ch;
        if (m_known) begin
            chk("din_dp1", din_dp1, e_dp1);
            chk("din_dp2", din_dp2, e_dp2);
            chk("din_dv", din_dv, e_dv);
            chk("din_chn", din_chn, e_chn);
            chk("sync_in", sync_in, e_sync);
            chk("underflow", underflow, e_under);
            chk("busy", busy, e_busy);
        end
        rst = r; enable = en; ch_mask = m; req_valid = v; underflow_clr = clr;
        for (int c = 0; c < N; c++)
            for (int l = 0; l < 2; l++) begin
                req_dp1[c][l] = rnd ? 16'($urandom) : 16'(32'h1000 * (c + 1) + l);
                req_dp2[c][l] = rnd ? 16'($urandom) : 16'(32'h2000 + c * 16 + l);
            end
        #1;
        e_ready = '0;
        miss    = '0;
        ch      = 0;
        if (!r && m_active && (m_pos % S == 0)) begin
            ch = m_pos / S;
            if (m_mask[ch]) begin
                if (v[ch]) e_ready[ch] = 1'b1;
                else       miss[ch]    = 1'b1;
            end
        end
        if (m_known || r) chk("req_ready", req_ready, e_ready);
        if (r) begin
            m_known = 1'b1; m_active = 1'b0; m_pos = 0; m_mask = '0;
            e_dp1 = '0; e_dp2 = '0; e_dv = 1'b0; e_sync = 1'b0;
            e_busy = 1'b0; e_chn = '0; e_under = '0;
        end else begin
            e_dv = |e_ready;
            if (e_dv) begin
                e_dp1 = req_dp1[ch];
                e_dp2 = req_dp2[ch];
                e_chn = 8'(ch);
            end
            e_sync  = m_active && (m_pos == 0);
            e_under = (clr ? '0 : e_under) | miss;
            if (!m_active) begin
                if (en) begin
                    m_active = 1'b1; m_pos = 0; m_mask = m;
                end
            end else if (m_pos == R - 1) begin
                m_pos = 0; m_mask = m; m_active = en;
            end else begin
                m_pos++;
            end
            e_busy = m_active;
        end
        @(negedge clk);
    endtask

    task automatic align(input int pos);
        for (int k = 0; k < R && m_pos != pos; k++) step(0, 1, 4'hF, 4'hF, 0, 0);
    endtask

    initial begin
        bit en;
        logic [N-1:0] msk, v;
        step(1, 0, 4'hF, 4'hF, 0, 0);
        step(1, 0, 4'hF, 4'hF, 0, 0);
        chk("reset_dv", din_dv, 0);
        chk("reset_busy", busy, 0);
        chk("reset_under", underflow, 0);
        chk("reset_sync", sync_in, 0);

        for (int i = 0; i < 20; i++) begin
            step(0, 1, 4'hF, 4'hF, 0, 0);
            if (i == 1) begin
                chk("first_dv", din_dv, 1);
                chk("first_chn", din_chn, 0);
                chk("first_sync", sync_in, 1);
                chk("first_dp1", din_dp1, 32'h1001_1000);
            end
            if (i == 3) chk("second_chn", din_chn, 1);
        end

        for (int i = 0; i < R; i++) step(0, 1, 4'hF, 4'b1011, 0, 0);
        chk("under_set", underflow, 4'b0100);
        align(4);
        step(0, 1, 4'hF, 4'b1011, 1, 0);
        chk("under_set_beats_clr", underflow, 4'b0100);
        step(0, 1, 4'hF, 4'hF, 1, 0);
        chk("under_clr", underflow, 4'b0000);

        for (int i = 0; i < 2 * R; i++) step(0, 1, 4'b1010, 4'hF, 0, 0);
        align(2);
        for (int i = 0; i < 10; i++) step(0, 0, 4'hF, 4'hF, 0, 0);
        chk("drain_idle", busy, 0);

        align(0);
        for (int i = 0; i < 3; i++) step(0, 1, 4'hF, 4'hF, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 1, 4'h1, 4'hF, 0, 0);
        step(1, 1, 4'hF, 4'hF, 0, 0);

        en  = 1'b1;
        msk = 4'hF;
        for (int i = 0; i < 4000; i++) begin
            if (en ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 9) == 0)) en = !en;
            if ($urandom_range(0, 29) == 0) msk = N'($urandom);
            for (int c = 0; c < N; c++) v[c] = ($urandom_range(0, 99) < 85);
            step(($urandom_range(0, 299) == 0), en, msk, v,
                 ($urandom_range(0, 19) == 0), 1);
        end
        step(0, 0, 4'hF, 4'hF, 0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
